// File: rtl/fa_response_checker_if.sv
// Bundle between a full-adder under test (plus its stimulus) and the response checker.
interface fa_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             finish;
    logic             valid;
    logic             a;
    logic             b;
    logic             cin;
    logic             sum;
    logic             cout;
    logic             mismatch;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] sample_count;
    logic [7:0]       coverage;
    logic [4:0]       first_fail;
    logic             busy;
    logic             pass;
    logic             fail;

    modport master (
        output start, finish, valid, a, b, cin, sum, cout,
        input  mismatch, err_count, sample_count, coverage, first_fail, busy, pass, fail
    );

    modport slave (
        input  start, finish, valid, a, b, cin, sum, cout,
        output mismatch, err_count, sample_count, coverage, first_fail, busy, pass, fail
    );
endinterface

// File: rtl/fa_response_checker.sv
// Self-checking monitor for a full-adder: golden compare, combo coverage, counters, PASS/FAIL verdict.
// IDLE: waiting for start | RUN: collecting samples | PASS: verdict good | FAIL: verdict bad
module fa_response_checker #(
    parameter int CNT_W       = 8,
    parameter bit STOP_ON_ERR = 1'b0,
    parameter int MIN_SAMPLES = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    fa_response_checker_if.slave chk_if
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PASS, ST_FAIL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [31:0]      MIN_SMP = 32'(MIN_SAMPLES);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic [7:0]       cov_q, cov_d;
    logic [4:0]       ff_q, ff_d;
    logic             mis_q, mis_d;
    logic             exp_sum, exp_cout, bad;

    assign exp_sum  = chk_if.a ^ chk_if.b ^ chk_if.cin;
    assign exp_cout = (chk_if.a & chk_if.b) | (chk_if.a & chk_if.cin) | (chk_if.b & chk_if.cin);
    assign bad      = chk_if.valid && ((chk_if.sum != exp_sum) || (chk_if.cout != exp_cout));

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        smp_d   = smp_q;
        cov_d   = cov_q;
        ff_d    = ff_q;
        mis_d   = 1'b0;
        // start wins over everything, including a same-cycle sample
        if (chk_if.start) begin
            state_d = ST_RUN;
            err_d   = '0;
            smp_d   = '0;
            cov_d   = '0;
            ff_d    = '0;
        end else if (state_q == ST_RUN) begin
            if (chk_if.valid) begin
                if (smp_q != CNT_MAX) smp_d = smp_q + 1'b1;
                cov_d[{chk_if.a, chk_if.b, chk_if.cin}] = 1'b1;
            end
            if (bad) begin
                mis_d = 1'b1;
                if (err_q == '0) ff_d = {chk_if.a, chk_if.b, chk_if.cin, chk_if.sum, chk_if.cout};
                if (err_q != CNT_MAX) err_d = err_q + 1'b1;
            end
            // verdict uses the post-sample statistics so a same-cycle sample counts
            if (STOP_ON_ERR && bad) begin
                state_d = ST_FAIL;
            end else if (chk_if.finish) begin
                state_d = (err_d == '0 && cov_d == 8'hFF && 32'(smp_d) >= MIN_SMP) ? ST_PASS : ST_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            err_q   <= '0;
            smp_q   <= '0;
            cov_q   <= '0;
            ff_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            smp_q   <= smp_d;
            cov_q   <= cov_d;
            ff_q    <= ff_d;
            mis_q   <= mis_d;
        end
    end

    assign chk_if.mismatch     = mis_q;
    assign chk_if.err_count    = err_q;
    assign chk_if.sample_count = smp_q;
    assign chk_if.coverage     = cov_q;
    assign chk_if.first_fail   = ff_q;
    assign chk_if.busy         = (state_q == ST_RUN);
    assign chk_if.pass         = (state_q == ST_PASS);
    assign chk_if.fail         = (state_q == ST_FAIL);
endmodule

// File: tb/tb_fa_response_checker.sv
// Bench for fa_response_checker: three configurations share one stimulus and are compared to a reference model.
module tb_fa_response_checker;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic st_r = 0, fi_r = 0, v_r = 0, a_r = 0, b_r = 0, c_r = 0, s_r = 0, co_r = 0;

    fa_response_checker_if #(.CNT_W(8)) if0 ();
    fa_response_checker_if #(.CNT_W(8)) if1 ();
    fa_response_checker_if #(.CNT_W(3)) if2 ();

    assign if0.start = st_r; assign if0.finish = fi_r; assign if0.valid = v_r; assign if0.a = a_r;
    assign if0.b = b_r; assign if0.cin = c_r; assign if0.sum = s_r; assign if0.cout = co_r;
    assign if1.start = st_r; assign if1.finish = fi_r; assign if1.valid = v_r; assign if1.a = a_r;
    assign if1.b = b_r; assign if1.cin = c_r; assign if1.sum = s_r; assign if1.cout = co_r;
    assign if2.start = st_r; assign if2.finish = fi_r; assign if2.valid = v_r; assign if2.a = a_r;
    assign if2.b = b_r; assign if2.cin = c_r; assign if2.sum = s_r; assign if2.cout = co_r;

    fa_response_checker #(.CNT_W(8), .STOP_ON_ERR(1'b0), .MIN_SAMPLES(8)) dut0 (.clk(clk), .rst_n(rst_n), .chk_if(if0));
    fa_response_checker #(.CNT_W(8), .STOP_ON_ERR(1'b1), .MIN_SAMPLES(8)) dut1 (.clk(clk), .rst_n(rst_n), .chk_if(if1));
    fa_response_checker #(.CNT_W(3), .STOP_ON_ERR(1'b0), .MIN_SAMPLES(8)) dut2 (.clk(clk), .rst_n(rst_n), .chk_if(if2));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference model: one verdict record per configuration
    localparam int M_IDLE = 0, M_RUN = 1, M_PASS = 2, M_FAIL = 3;
    int cfg_w[3]   = '{8, 8, 3};
    int cfg_soe[3] = '{0, 1, 0};
    int m_state[3], m_err[3], m_smp[3], m_cov[3], m_ff[3], m_mis[3];

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_state[k] = M_IDLE; m_err[k] = 0; m_smp[k] = 0; m_cov[k] = 0; m_ff[k] = 0; m_mis[k] = 0;
        end
    endfunction

    function automatic void model_step();
        int tot, sat, bad;
        tot = int'(a_r) + int'(b_r) + int'(c_r);
        for (int k = 0; k < 3; k++) begin
            sat = (1 << cfg_w[k]) - 1;
            m_mis[k] = 0;
            if (st_r) begin
                m_state[k] = M_RUN; m_err[k] = 0; m_smp[k] = 0; m_cov[k] = 0; m_ff[k] = 0;
            end else if (m_state[k] == M_RUN) begin
                bad = 0;
                if (v_r) begin
                    if (m_smp[k] < sat) m_smp[k]++;
                    m_cov[k] |= 1 << (4 * int'(a_r) + 2 * int'(b_r) + int'(c_r));
                    bad = (int'(s_r) != tot % 2) || (int'(co_r) != tot / 2);
                end
                if (bad) begin
                    m_mis[k] = 1;
                    if (m_err[k] == 0)
                        m_ff[k] = 16 * int'(a_r) + 8 * int'(b_r) + 4 * int'(c_r) + 2 * int'(s_r) + int'(co_r);
                    if (m_err[k] < sat) m_err[k]++;
                end
                if (cfg_soe[k] != 0 && bad) m_state[k] = M_FAIL;
                else if (fi_r)
                    m_state[k] = (m_err[k] == 0 && m_cov[k] == 255 && m_smp[k] >= 8) ? M_PASS : M_FAIL;
            end
        end
    endfunction

    task automatic cmp_dut(int k, int mis, int err, int smp, int cov, int ff, int busy, int pass, int fail);
        check($sformatf("d%0d.mismatch", k), mis, m_mis[k]);
        check($sformatf("d%0d.err_count", k), err, m_err[k]);
        check($sformatf("d%0d.sample_count", k), smp, m_smp[k]);
        check($sformatf("d%0d.coverage", k), cov, m_cov[k]);
        check($sformatf("d%0d.first_fail", k), ff, m_ff[k]);
        check($sformatf("d%0d.busy", k), busy, int'(m_state[k] == M_RUN));
        check($sformatf("d%0d.pass", k), pass, int'(m_state[k] == M_PASS));
        check($sformatf("d%0d.fail", k), fail, int'(m_state[k] == M_FAIL));
    endtask

    task automatic compare_models();
        cmp_dut(0, int'(if0.mismatch), int'(if0.err_count), int'(if0.sample_count), int'(if0.coverage),
                int'(if0.first_fail), int'(if0.busy), int'(if0.pass), int'(if0.fail));
        cmp_dut(1, int'(if1.mismatch), int'(if1.err_count), int'(if1.sample_count), int'(if1.coverage),
                int'(if1.first_fail), int'(if1.busy), int'(if1.pass), int'(if1.fail));
        cmp_dut(2, int'(if2.mismatch), int'(if2.err_count), int'(if2.sample_count), int'(if2.coverage),
                int'(if2.first_fail), int'(if2.busy), int'(if2.pass), int'(if2.fail));
    endtask

    task automatic cycle(bit st, bit fi, bit v, bit a, bit b, bit c, bit s, bit co);
        @(negedge clk);
        st_r = st; fi_r = fi; v_r = v; a_r = a; b_r = b; c_r = c; s_r = s; co_r = co;
        @(posedge clk);
        model_step();
        #1;
        compare_models();
    endtask

    // Correct adder response for combo index {a,b,cin}
    function automatic int good_sum(int combo);
        return ((combo >> 2) + ((combo >> 1) & 1) + (combo & 1)) % 2;
    endfunction
    function automatic int good_cout(int combo);
        return ((combo >> 2) + ((combo >> 1) & 1) + (combo & 1)) / 2;
    endfunction

    task automatic sample(int combo, bit corrupt_sum);
        bit s;
        s = bit'(good_sum(combo)) ^ corrupt_sum;
        cycle(0, 0, 1, bit'(combo >> 2), bit'((combo >> 1) & 1), bit'(combo & 1), s, bit'(good_cout(combo)));
    endtask

    typedef struct {
        bit st, fi, v, a, b, c, s, co;
        int e_mis, e_busy, e_pass, e_fail, e_err, e_smp;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit st, bit fi, bit v, int combo, bit s, bit co,
                                int mis, int busy, int pass, int fail, int err, int smp);
        vec_t r;
        r.st = st; r.fi = fi; r.v = v;
        r.a = bit'(combo >> 2); r.b = bit'((combo >> 1) & 1); r.c = bit'(combo & 1);
        r.s = s; r.co = co;
        r.e_mis = mis; r.e_busy = busy; r.e_pass = pass; r.e_fail = fail; r.e_err = err; r.e_smp = smp;
        tbl.push_back(r);
    endfunction

    int order[8] = '{0, 2, 4, 6, 1, 3, 5, 7};

    initial begin
        // Directed table for the default configuration: clean run, then a run with one bad sample (011, sum=1, cout=0)
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            add(0, 0, 1, order[i], bit'(good_sum(order[i])), bit'(good_cout(order[i])), 0, 1, 0, 0, 0, i + 1);
        add(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 8);
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            if (order[i] == 3) add(0, 0, 1, 3, 1, 0, 1, 1, 0, 0, 1, i + 1);
            else add(0, 0, 1, order[i], bit'(good_sum(order[i])), bit'(good_cout(order[i])),
                     0, 1, 0, 0, (i > 5) ? 1 : 0, i + 1);
        end
        add(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 8);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_models();
        check("reset.pass", int'(if0.pass), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            cycle(tbl[i].st, tbl[i].fi, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].co);
            check($sformatf("tbl%0d.mismatch", i), int'(if0.mismatch), tbl[i].e_mis);
            check($sformatf("tbl%0d.busy", i), int'(if0.busy), tbl[i].e_busy);
            check($sformatf("tbl%0d.pass", i), int'(if0.pass), tbl[i].e_pass);
            check($sformatf("tbl%0d.fail", i), int'(if0.fail), tbl[i].e_fail);
            check($sformatf("tbl%0d.err_count", i), int'(if0.err_count), tbl[i].e_err);
            check($sformatf("tbl%0d.sample_count", i), int'(if0.sample_count), tbl[i].e_smp);
        end
        check("first_fail_011", int'(if0.first_fail), 5'b01110);
        check("coverage_full", int'(if0.coverage), 8'hFF);

        // Stop-on-error: third sample bad
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        sample(0, 0); sample(1, 0); sample(2, 1);
        check("soe.fail_now", int'(if1.fail), 1);
        check("soe.smp3", int'(if1.sample_count), 3);
        check("soe.other_busy", int'(if0.busy), 1);
        sample(3, 0); sample(4, 0);
        check("soe.frozen_smp", int'(if1.sample_count), 3);
        check("soe.mis_gone", int'(if1.mismatch), 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("soe.still_fail", int'(if1.fail), 1);

        // Seven combos only
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) sample(c, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0);
        check("cov7.fail", int'(if0.fail), 1);
        check("cov7.coverage", int'(if0.coverage), 8'h7F);

        // Saturation with narrow counters
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) sample(i % 8, 1);
        check("sat.err3", int'(if2.err_count), 7);
        check("sat.smp3", int'(if2.sample_count), 7);
        check("sat.err8", int'(if0.err_count), 10);

        // Finish together with the last sample still counts it
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 7; c++) sample(c, 0);
        cycle(0, 1, 1, 1, 1, 1, 1, 1);
        check("fin_with_valid.pass", int'(if0.pass), 1);

        // Async reset mid-run
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        sample(5, 0); sample(6, 1); sample(7, 0);
        @(negedge clk);
        st_r = 0; v_r = 0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        compare_models();
        check("arst.busy", int'(if0.busy), 0);
        check("arst.err", int'(if0.err_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        check("arst.restart_busy", int'(if0.busy), 1);
        sample(4, 0);
        check("arst.restart_smp", int'(if0.sample_count), 1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            bit st, fi, v, ca, cb, cc, cs, cco;
            int combo;
            st = ($urandom % 40) == 0;
            fi = ($urandom % 20) == 0;
            v = ($urandom % 4) != 0;
            combo = int'($urandom % 8);
            ca = bit'(combo >> 2); cb = bit'((combo >> 1) & 1); cc = bit'(combo & 1);
            cs = bit'(good_sum(combo)); cco = bit'(good_cout(combo));
            if (($urandom % 30) == 0) cs = ~cs;
            if (($urandom % 30) == 0) cco = ~cco;
            cycle(st, fi, v, ca, cb, cc, cs, cco);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
